// File: rtl/nanci_edge_drain.sv
// ---------------------------------------------------------------------------
// nanci_edge_drain
//
// Drain stage that sits directly downstream of an edge PE. A start pulse opens
// a window of DRAIN_CYCLES samples of the PE output stream. Sampled words are
// buffered in a small show-ahead FIFO and handed to the host over a
// valid/ready handshake. Completion is signalled once the window has closed
// and the FIFO is empty.
//
// Optional feature macro: NANCI_DRAIN_FILTER_EN
//   defined   -> words equal to MAX_INT (empty-slot marker) are discarded.
//   undefined -> every sampled word is buffered, MAX_INT included.
//
// Handshake: a word moves to the consumer on every rising edge where
// o_valid && i_ready. o_data is the FIFO head and holds steady while o_valid
// is high and i_ready is low. Popping is allowed in every state.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         asynchronous active-high reset
//   i_start     opens a drain window (honoured only in IDLE)
//   i_PE        word from the edge PE: {address, data}
//   o_valid     FIFO head is valid
//   o_data      FIFO head word (show-ahead), zero when empty
//   i_ready     consumer accepts the head this cycle
//   o_busy      high whenever the FSM is not in IDLE
//   o_done      one-cycle pulse when the window is closed and drained
//   o_overflow  sticky: a word was dropped on a full FIFO
// ---------------------------------------------------------------------------
module nanci_edge_drain #(
    parameter int ADDR_WIDTH   = 3,
    parameter int DATA_WIDTH   = 3,
    parameter logic [ADDR_WIDTH+DATA_WIDTH-1:0] MAX_INT = '1,
    parameter int DRAIN_CYCLES = 4,
    parameter int DEPTH        = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_start,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] i_PE,
    output logic                             o_valid,
    output logic [ADDR_WIDTH+DATA_WIDTH-1:0] o_data,
    input  logic                             i_ready,
    output logic                             o_busy,
    output logic                             o_done,
    output logic                             o_overflow
);

    localparam int W    = ADDR_WIDTH + DATA_WIDTH;
    localparam int PW   = $clog2(DEPTH);
    localparam int OW   = PW + 1;
    localparam int CW   = $clog2(DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   sample_cnt;

    logic [W-1:0]    mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [OW-1:0]   occupancy;

    logic            sampling;
    logic            pass_filter;
    logic            fifo_full;
    logic            pop;
    logic            push;
    logic            drop;

    // ------------------------------------------------------------------
    // Datapath control
    // ------------------------------------------------------------------
    assign sampling  = (state == ST_DRAIN);
    assign fifo_full = (occupancy == OW'(DEPTH));
    assign o_valid   = (occupancy != '0);
    assign pop       = o_valid && i_ready;

`ifdef NANCI_DRAIN_FILTER_EN
    assign pass_filter = (i_PE != MAX_INT);
`else
    assign pass_filter = 1'b1;
`endif

    // A full FIFO still takes the word when the head leaves on the same edge.
    assign push = sampling && pass_filter && (!fifo_full || pop);
    assign drop = sampling && pass_filter && fifo_full && !pop;

    // Head is gated so the output reads zero when nothing is buffered.
    assign o_data = o_valid ? mem[rd_ptr] : '0;

    // ------------------------------------------------------------------
    // FIFO storage (no reset needed: contents are only visible through
    // the occupancy-gated head)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_PE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                occupancy <= occupancy + OW'(1);
            end else if (pop && !push) begin
                occupancy <= occupancy - OW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Window FSM with registered status outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            sample_cnt <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state      <= ST_DRAIN;
                        sample_cnt <= '0;
                        o_busy     <= 1'b1;
                        o_overflow <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    sample_cnt <= sample_cnt + CW'(1);
                    // This edge takes the final sample of the window.
                    if (sample_cnt == CW'(DRAIN_CYCLES - 1)) begin
                        state <= ST_FLUSH;
                    end
                    if (drop) begin
                        o_overflow <= 1'b1;
                    end
                end
                ST_FLUSH: begin
                    if (occupancy == '0) begin
                        state  <= ST_IDLE;
                        o_busy <= 1'b0;
                        o_done <= 1'b1;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/nanci_edge_drain.md
# nanci_edge_drain

Mesh-boundary drain stage that sits directly downstream of an edge `PE` and consumes its `o_PE` word stream. After a start pulse it samples the edge PE output for a fixed number of cycles and discards empty-slot markers (`MAX_INT`). It buffers the surviving {address, data} words in a small FIFO and presents them to the host side over a valid/ready handshake. It signals completion once the window has closed and the buffer has fully drained.

## Interface
Parameters:
- `ADDR_WIDTH`, 3, address field width; must match the feeding PE
- `DATA_WIDTH`, 3, data field width; must match the feeding PE
- `MAX_INT`, all ones (`ADDR_WIDTH+DATA_WIDTH` bits), empty-slot marker value
- `DRAIN_CYCLES`, 4, number of cycles `i_PE` is sampled per drain window (≥1)
- `DEPTH`, 4, FIFO entries (power of two, ≥2)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `i_start`  in  1  begin a drain window; honoured only in IDLE
- `i_PE`  in  ADDR_WIDTH+DATA_WIDTH  word from the edge PE `o_PE`
- `o_valid`  out  1  FIFO head is valid
- `o_data`  out  ADDR_WIDTH+DATA_WIDTH  FIFO head word (show-ahead)
- `i_ready`  in  1  consumer accepts the head this cycle
- `o_busy`  out  1  state ≠ IDLE
- `o_done`  out  1  one-cycle pulse at the end of a window
- `o_overflow`  out  1  sticky: a word was dropped because the FIFO was full

## Operation
- States:
  - IDLE: `i_start`=1 → DRAIN, with sample counter = 0.
  - DRAIN: samples `i_PE` on every edge and increments the counter. When the counter reaches `DRAIN_CYCLES` on the last sample → FLUSH. `i_start` is ignored.
  - FLUSH: when FIFO occupancy = 0 → pulse `o_done` and go to IDLE. `i_start` is ignored.
- Push: a sampled word is pushed when it passes the filter (see Configuration) and the FIFO is not full, or is full but a pop occurs on the same edge.
- Drop: a word that passes the filter but finds the FIFO full with no pop is dropped, and `o_overflow` is set. `o_overflow` is cleared only by reset or by a new `i_start` accepted in IDLE.
- Pop: occurs on an edge where `o_valid && i_ready`. Popping is allowed in every state, including IDLE.
- Occupancy counter: width log2(DEPTH)+1. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- Simultaneous push and pop: occupancy is unchanged. This is legal when full and when holding one entry.
- Fields: the address is `i_PE[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH]` and the data is the low `DATA_WIDTH` bits. The block forwards the word unchanged and never alters either field.

## Timing
- Reset values: all outputs 0; state IDLE; FIFO empty; counter 0.
- `rst` asserted mid-window aborts immediately. FIFO contents are lost and no `o_done` is emitted.
- Window timing: `i_start` is sampled high at edge k. `i_PE` is then sampled at edges k+1 … k+DRAIN_CYCLES. `o_busy` is high from just after edge k.
- Latency: a word pushed at edge t appears on `o_valid`/`o_data` after edge t when the FIFO was empty. Otherwise it appears behind older entries.
- `o_done` timing:
  - It is high for exactly the one cycle following the edge where FLUSH observes occupancy 0.
  - `o_busy` falls together with the `o_done` pulse.
  - With an empty FIFO at the end of DRAIN, `o_done` rises one edge after the last sample.
- Handshake: `o_data` is stable while `o_valid`=1 and `i_ready`=0.

## Configuration
- `NANCI_DRAIN_FILTER_EN` defined: words equal to `MAX_INT` are discarded and never pushed or counted as overflow.
- `NANCI_DRAIN_FILTER_EN` undefined: every sampled word, including `MAX_INT`, is pushed.

## Test plan
Common settings for every scenario: ADDR_WIDTH=3, DATA_WIDTH=3, DEPTH=4, DRAIN_CYCLES=4, filter enabled unless stated.
- Basic drain:
  - Stimulus: `i_PE` = 6'b000_001, 6'b001_010, 6'b111_111, 6'b010_011 over the window, with `i_ready`=1.
  - Required response: `o_data` shows 000_001, 001_010, 010_011 in order; `o_done` pulses once; `o_overflow`=0.
- Backpressure:
  - Stimulus: `i_ready`=0 throughout a window of 4 non-MAX words.
  - Required response: occupancy 4 and `o_valid`=1 with the head equal to the first word. `o_done` waits in FLUSH until `i_ready` has been raised and four pops complete.
- Overflow:
  - Stimulus: `i_ready`=0 with DRAIN_CYCLES=6 and six non-MAX words.
  - Required response: the first four words are kept, `o_overflow`=1, and the sticky flag clears on the next accepted `i_start`.
- Full with pop:
  - Stimulus: FIFO full while `i_ready`=1 during DRAIN.
  - Required response: the push is accepted each cycle and `o_overflow` stays 0.
- Start ignored and reset abort:
  - Stimulus: `i_start` pulsed during DRAIN or FLUSH.
  - Required response: no effect.
  - Stimulus: `rst` pulsed mid-DRAIN.
  - Required response: all outputs are 0 at once and there is no `o_done`.
- Filter disabled:
  - Stimulus: the same stimulus as basic drain with `NANCI_DRAIN_FILTER_EN` undefined.
  - Required response: four words delivered, with 111_111 third.
